// File: rtl/regfile_sb_pkg.sv
// Shared defaults, counter-operation encoding and helpers for the scoreboarded register file.
package regfile_sb_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREG_DEF  = 32;
    localparam int NRD_DEF   = 2;
    localparam int CNT_W_DEF = 2;
    localparam int REG_ZERO  = 0;

    typedef enum logic [1:0] {
        CNT_HOLD,
        CNT_INC,
        CNT_DEC,
        CNT_CLR
    } cnt_op_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Decode/write-back facing bundle of the scoreboarded register file.
interface regfile_sb_if
    import regfile_sb_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF,
    parameter int NRD  = NRD_DEF
) ();

    localparam int AW = clog2(NREG);

    logic [NRD-1:0]      rd_en;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic                wb_en;
    logic [AW-1:0]       wb_addr;
    logic [XLEN-1:0]     wb_data;
    logic                iss_en;
    logic [AW-1:0]       iss_addr;
    logic                iss_ready;
    logic                flush;
    logic                conflict;
    logic                err_uf;
    logic [AW-1:0]       dbg_addr;
    logic [XLEN-1:0]     dbg_data;

    modport master (
        output rd_en, rd_addr, wb_en, wb_addr, wb_data,
        output iss_en, iss_addr, flush, dbg_addr,
        input  rd_data, iss_ready, conflict, err_uf, dbg_data
    );

    modport slave (
        input  rd_en, rd_addr, wb_en, wb_addr, wb_data,
        input  iss_en, iss_addr, flush, dbg_addr,
        output rd_data, iss_ready, conflict, err_uf, dbg_data
    );

endinterface

// File: rtl/regfile_sb_cnt.sv
// One saturating pending-write counter; inc and dec together cancel, clr wins over both.
module regfile_sb_cnt
    import regfile_sb_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             nz,
    output logic             full,
    output logic             uf_pulse
);

    logic [CNT_W-1:0] cnt_q;
    cnt_op_e          op;

    assign cnt      = cnt_q;
    assign nz       = |cnt_q;
    assign full     = &cnt_q;
    assign uf_pulse = dec & ~inc & ~clr & ~nz;

    always_comb begin
        op = CNT_HOLD;
        if (clr) begin
            op = CNT_CLR;
        end else if (inc && !dec && !full) begin
            op = CNT_INC;
        end else if (dec && !inc && nz) begin
            op = CNT_DEC;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            case (op)
                CNT_CLR: cnt_q <= '0;
                CNT_INC: cnt_q <= cnt_q + 1'b1;
                CNT_DEC: cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Register file with per-register pending-write counters, flush and sticky underflow flag.
// Define REGFILE_SB_BYPASS_EN to forward a same-cycle write-back onto the read ports.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREG  = NREG_DEF,
    parameter int NRD   = NRD_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input logic         clk,
    input logic         rst_n,
    regfile_sb_if.slave bus
);

    localparam int AW = clog2(NREG);

    logic [XLEN-1:0]       mem_q [NREG];
    logic [NREG*CNT_W-1:0] cnt_flat;
    logic [NREG-1:0]       nz_vec;
    logic [NREG-1:0]       full_vec;
    logic [NREG-1:0]       uf_vec;
    logic [AW-1:0]         rd_addr_a [NRD];
    logic [NRD-1:0]        hit_vec;
    logic [NRD*XLEN-1:0]   rd_data_w;
    logic                  acc;
    logic                  ret;
    logic                  err_uf_q;

    assign bus.iss_ready = (bus.iss_addr == AW'(REG_ZERO)) | ~full_vec[bus.iss_addr];
    assign acc = bus.iss_en & bus.iss_ready & (bus.iss_addr != AW'(REG_ZERO));
    assign ret = bus.wb_en & (bus.wb_addr != AW'(REG_ZERO));

    // Entry 0 is never written, so its reset value keeps x0 reading as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                mem_q[r] <= '0;
            end
        end else if (ret) begin
            mem_q[bus.wb_addr] <= bus.wb_data;
        end
    end

    assign cnt_flat[CNT_W-1:0] = '0;
    assign nz_vec[0]           = 1'b0;
    assign full_vec[0]         = 1'b0;
    assign uf_vec[0]           = 1'b0;

    for (genvar r = 1; r < NREG; r++) begin : g_cnt
        regfile_sb_cnt #(.CNT_W(CNT_W)) u_cnt (
            .clk      (clk),
            .rst_n    (rst_n),
            .inc      (acc & (bus.iss_addr == AW'(r))),
            .dec      (ret & (bus.wb_addr == AW'(r))),
            .clr      (bus.flush),
            .cnt      (cnt_flat[r*CNT_W +: CNT_W]),
            .nz       (nz_vec[r]),
            .full     (full_vec[r]),
            .uf_pulse (uf_vec[r])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_uf_q <= 1'b0;
        end else if (|uf_vec) begin
            err_uf_q <= 1'b1;
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic base_hit;

        assign rd_addr_a[p] = bus.rd_addr[p*AW +: AW];
        assign base_hit     = bus.rd_en[p] & (rd_addr_a[p] != AW'(REG_ZERO)) & nz_vec[rd_addr_a[p]];
`ifdef REGFILE_SB_BYPASS_EN
        logic fwd;

        // Forwarding only hides the youngest writer; older pending writers still conflict.
        assign fwd                        = rst_n & ret & (bus.wb_addr == rd_addr_a[p]);
        assign rd_data_w[p*XLEN +: XLEN]  = fwd ? bus.wb_data : mem_q[rd_addr_a[p]];
        assign hit_vec[p]                 = base_hit &
                                            ~(fwd & (cnt_flat[rd_addr_a[p]*CNT_W +: CNT_W] == CNT_W'(1)));
`else
        assign rd_data_w[p*XLEN +: XLEN]  = mem_q[rd_addr_a[p]];
        assign hit_vec[p]                 = base_hit;
`endif
    end

`ifndef REGFILE_SB_BYPASS_EN
    logic unused_cnt;
    assign unused_cnt = ^cnt_flat;
`endif

    assign bus.rd_data  = rd_data_w;
    assign bus.conflict = |hit_vec;
    assign bus.err_uf   = err_uf_q;
    assign bus.dbg_data = mem_q[bus.dbg_addr];

endmodule
